// File: rtl/tof_serial_receiver.sv
// Receives the LSB-first time-of-flight word framed by start_wire, sampling mid-bit.
// A good frame loads tof_value and holds done_ack until the sender drops start.
module tof_serial_receiver #(
    parameter int NUM_BITS   = 32,
    parameter int BIT_CYCLES = 10000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start_wire,
    input  logic                data_wire,
    input  logic                enable,
    output logic [NUM_BITS-1:0] tof_value,
    output logic                tof_valid,
    output logic                frame_error,
    output logic                busy,
    output logic                done_ack
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(NUM_BITS - 1);

    typedef enum logic [1:0] {IDLE, CENTER, SAMPLE, WAIT_LOW} state_t;

    state_t              state_q, state_d;
    logic                start_m_q, s_start_q, s_start_d_q;
    logic                data_m_q, s_data_q;
    logic [CW-1:0]       cyc_cnt_q, cyc_cnt_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [NUM_BITS-1:0] sh_q, sh_d, sh_next;
    logic [NUM_BITS-1:0] tof_value_q, tof_value_d;
    logic                tof_valid_q, tof_valid_d;
    logic                frame_error_q, frame_error_d;
    logic                busy_q, busy_d;
    logic                done_ack_q, done_ack_d;
    logic                rise, sample_now;

    assign rise       = s_start_q & ~s_start_d_q;
    assign sample_now = ((state_q == CENTER) && (cyc_cnt_q == HALF_LAST)) ||
                        ((state_q == SAMPLE) && (cyc_cnt_q == BIT_LAST));

    always_comb begin
        sh_next = sh_q >> 1;
        sh_next[NUM_BITS-1] = s_data_q;
    end

    always_comb begin
        state_d       = state_q;
        cyc_cnt_d     = cyc_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sh_d          = sh_q;
        tof_value_d   = tof_value_q;
        tof_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        done_ack_d    = done_ack_q;
        case (state_q)
            IDLE: begin
                if (rise && enable) begin
                    state_d   = CENTER;
                    cyc_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            CENTER, SAMPLE: begin
                // The final sample beats a simultaneous start drop.
                if (sample_now && (bit_cnt_q == BITS_LAST)) begin
                    sh_d        = sh_next;
                    bit_cnt_d   = bit_cnt_q + BW'(1);
                    tof_value_d = sh_next;
                    tof_valid_d = 1'b1;
                    done_ack_d  = 1'b1;
                    state_d     = WAIT_LOW;
                end else if (!s_start_q) begin
                    frame_error_d = 1'b1;
                    sh_d          = '0;
                    bit_cnt_d     = '0;
                    cyc_cnt_d     = '0;
                    state_d       = IDLE;
                end else if (sample_now) begin
                    sh_d      = sh_next;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    cyc_cnt_d = '0;
                    state_d   = SAMPLE;
                end else begin
                    cyc_cnt_d = cyc_cnt_q + CW'(1);
                end
            end
            WAIT_LOW: begin
                if (!s_start_q) begin
                    state_d    = IDLE;
                    done_ack_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            start_m_q     <= 1'b0;
            s_start_q     <= 1'b0;
            s_start_d_q   <= 1'b0;
            data_m_q      <= 1'b0;
            s_data_q      <= 1'b0;
            state_q       <= IDLE;
            cyc_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            sh_q          <= '0;
            tof_value_q   <= '0;
            tof_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
            done_ack_q    <= 1'b0;
        end else begin
            start_m_q     <= start_wire;
            s_start_q     <= start_m_q;
            s_start_d_q   <= s_start_q;
            data_m_q      <= data_wire;
            s_data_q      <= data_m_q;
            state_q       <= state_d;
            cyc_cnt_q     <= cyc_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sh_q          <= sh_d;
            tof_value_q   <= tof_value_d;
            tof_valid_q   <= tof_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
            done_ack_q    <= done_ack_d;
        end
    end

    assign tof_value   = tof_value_q;
    assign tof_valid   = tof_valid_q;
    assign frame_error = frame_error_q;
    assign busy        = busy_q;
    assign done_ack    = done_ack_q;

endmodule
